// File: rtl/spi_pkg.sv
// Shared SPI command definitions: opcode encoding, master FSM states and word sizes.
package spi_pkg;

    localparam int CMD_BITS  = 10;
    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_END     = 3'd5
    } mst_state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath for the SPI master: command shift-out register, read-data shift-in
// register and the shared bit counter. Next-state values are exported so the
// top level can register MOSI/rsp_data in the same cycle the state changes.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CMD_BITS-1:0]  load_data,
    input  logic                 shift_en,
    input  logic                 cap_en,
    input  logic                 miso,
    input  logic                 cnt_ld,
    input  logic [3:0]           cnt_ld_val,
    input  logic                 cnt_dec,
    output logic                 tx_msb_next,
    output logic [DATA_BITS-1:0] rx_next,
    output logic [3:0]           bit_cnt
);

    logic [CMD_BITS-1:0]  tx_q, tx_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;
    logic [3:0]           cnt_q, cnt_d;

    // Next values: parallel load / left shift, MSB-first capture, counter load or decrement.
    always_comb begin
        tx_d = tx_q;
        if (load) begin
            tx_d = load_data;
        end else if (shift_en) begin
            tx_d = {tx_q[CMD_BITS-2:0], 1'b0};
        end
        rx_d = cap_en ? {rx_q[DATA_BITS-2:0], miso} : rx_q;
        cnt_d = cnt_q;
        if (cnt_ld) begin
            cnt_d = cnt_ld_val;
        end else if (cnt_dec) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Datapath registers; reset drops any partially captured byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q  <= '0;
            rx_q  <= '0;
            cnt_q <= '0;
        end else begin
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            cnt_q <= cnt_d;
        end
    end

    assign tx_msb_next = tx_d[CMD_BITS-1];
    assign rx_next     = rx_d;
    assign bit_cnt     = cnt_q;

endmodule

// File: rtl/spi_master.sv
// SPI master: accepts 10-bit commands from the host, shifts them out MSB first
// under SS_n (one bit per clk), and for read-data commands collects an 8-bit
// reply from MISO after TURNAROUND idle cycles. All pin outputs are registered
// from the next state so they line up cycle-for-cycle with the FSM state.
module spi_master
    import spi_pkg::*;
#(
    parameter int TURNAROUND = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CMD_BITS-1:0]  cmd_data,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam logic [3:0] SHIFT_FIRST = 4'(CMD_BITS - 1);
    localparam logic [3:0] CAP_FIRST   = 4'(DATA_BITS - 1);
    localparam logic [3:0] WAIT_LAST   = (TURNAROUND == 0) ? 4'd0 : 4'(TURNAROUND - 1);

    mst_state_e           state_q, state_d;
    logic                 rd_q, rd_d;
    logic [3:0]           wait_q, wait_d;
    logic                 ss_n_q, ss_n_d;
    logic                 mosi_q, mosi_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;

    logic                 load, shift_en, cap_en, cnt_ld, cnt_dec;
    logic [3:0]           cnt_ld_val;
    logic                 tx_msb_next;
    logic [DATA_BITS-1:0] rx_next;
    logic [3:0]           bit_cnt;

    spi_master_shifter u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_data   (cmd_data),
        .shift_en    (shift_en),
        .cap_en      (cap_en),
        .miso        (MISO),
        .cnt_ld      (cnt_ld),
        .cnt_ld_val  (cnt_ld_val),
        .cnt_dec     (cnt_dec),
        .tx_msb_next (tx_msb_next),
        .rx_next     (rx_next),
        .bit_cnt     (bit_cnt)
    );

    // Frame sequencing and datapath control.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wait_d     = wait_q;
        load       = 1'b0;
        shift_en   = 1'b0;
        cap_en     = 1'b0;
        cnt_ld     = 1'b0;
        cnt_ld_val = 4'd0;
        cnt_dec    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    load    = 1'b1;
                    rd_d    = (spi_op_e'(cmd_data[CMD_BITS-1 -: 2]) == RD_DATA);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_ld     = 1'b1;
                cnt_ld_val = SHIFT_FIRST;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt == 4'd0) begin
                    if (!rd_q) begin
                        state_d = ST_END;
                    end else if (TURNAROUND == 0) begin
                        cnt_ld     = 1'b1;
                        cnt_ld_val = CAP_FIRST;
                        state_d    = ST_CAPTURE;
                    end else begin
                        wait_d  = WAIT_LAST;
                        state_d = ST_WAIT;
                    end
                end else begin
                    shift_en = 1'b1;
                    cnt_dec  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (wait_q == 4'd0) begin
                    cnt_ld     = 1'b1;
                    cnt_ld_val = CAP_FIRST;
                    state_d    = ST_CAPTURE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                cap_en = 1'b1;
                if (bit_cnt == 4'd0) begin
                    state_d = ST_END;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin outputs for the coming cycle, derived from the state being entered.
    always_comb begin
        ss_n_d      = (state_d == ST_IDLE) || (state_d == ST_END);
        mosi_d      = ((state_d == ST_START) || (state_d == ST_SHIFT)) ? tx_msb_next : 1'b0;
        rsp_valid_d = (state_d == ST_END) && rd_q;
        rsp_data_d  = ((state_q == ST_CAPTURE) && (state_d == ST_END)) ? rx_next : rsp_data_q;
    end

    // State and registered outputs; reset raises SS_n at once and clears read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_q        <= 1'b0;
            wait_q      <= 4'd0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wait_q      <= wait_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a TURNAROUND=2 instance and a TURNAROUND=0 instance,
// driven by table vectors, hand sequences and random frames, each cycle
// compared against a frame-level reference built from the command word.
module tb_spi_master;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       ss_n;
        logic       mosi;
        logic       rv;
        logic [7:0] rdata;
    } obs_t;

    typedef struct {
        bit         z;
        logic [9:0] cmd;
        logic [7:0] rbyte;
        bit         noisy;
        int         exp_rv;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       cmd_valid_a = 1'b0, cmd_valid_z = 1'b0;
    logic [9:0] cmd_data_a = '0, cmd_data_z = '0;
    logic       miso_a = 1'b0, miso_z = 1'b0;
    logic       cmd_ready_a, busy_a, ss_n_a, mosi_a, rsp_valid_a;
    logic       cmd_ready_z, busy_z, ss_n_z, mosi_z, rsp_valid_z;
    logic [7:0] rsp_data_a, rsp_data_z;
    obs_t       obs_a, obs_z;

    int checks = 0;
    int failures = 0;
    logic [7:0] model_rsp_a = 8'h00;
    logic [7:0] model_rsp_z = 8'h00;

    always #5 clk = ~clk;

    spi_master #(.TURNAROUND(2)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_data(cmd_data_a), .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a),
        .busy(busy_a), .SS_n(ss_n_a), .MOSI(mosi_a), .MISO(miso_a)
    );

    spi_master #(.TURNAROUND(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_z), .cmd_ready(cmd_ready_z),
        .cmd_data(cmd_data_z), .rsp_valid(rsp_valid_z), .rsp_data(rsp_data_z),
        .busy(busy_z), .SS_n(ss_n_z), .MOSI(mosi_z), .MISO(miso_z)
    );

    assign obs_a = {cmd_ready_a, busy_a, ss_n_a, mosi_a, rsp_valid_a, rsp_data_a};
    assign obs_z = {cmd_ready_z, busy_z, ss_n_z, mosi_z, rsp_valid_z, rsp_data_z};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit z, input logic v, input logic [9:0] d, input logic m);
        if (z) begin
            cmd_valid_z = v; cmd_data_z = d; miso_z = m;
        end else begin
            cmd_valid_a = v; cmd_data_a = d; miso_a = m;
        end
    endtask

    // One frame: offer cmd at the first ready cycle, then compare every cycle
    // up to the IDLE cycle after END against the frame shape implied by cmd.
    // A nonzero abort_k returns just after the posedge opening cycle T+abort_k.
    task automatic do_frame(input bit z, input logic [9:0] cmd, input logic [7:0] rbyte,
                            input bit noisy, input int abort_k,
                            output int rv_count, output logic [7:0] end_data);
        obs_t o;
        int   ta, n, waitc;
        bit   rd;
        logic m;
        logic [7:0] exp_rsp;
        ta = z ? 0 : 2;
        rd = (cmd[9:8] == 2'b11);
        n  = rd ? 19 + ta : 11;
        rv_count = 0;
        end_data = '0;
        waitc = 0;
        o = z ? obs_z : obs_a;
        while (!o.ready && waitc < 40) begin
            @(negedge clk);
            waitc++;
            o = z ? obs_z : obs_a;
        end
        if (!o.ready) begin
            check("ready_timeout", 32'(o.ready), 32'd1);
            return;
        end
        drive(z, 1'b1, cmd, 1'($urandom));
        for (int k = 1; k <= n + 2; k++) begin
            @(posedge clk);
            #1;
            if (rd && k >= 12 + ta && k <= 19 + ta) m = rbyte[19 + ta - k];
            else m = 1'($urandom);
            if (noisy && k <= n + 1) drive(z, 1'b1, 10'($urandom), m);
            else drive(z, 1'b0, cmd, m);
            if (abort_k == k) return;
            @(negedge clk);
            o = z ? obs_z : obs_a;
            if (k <= n) begin
                check("ss_low", 32'(o.ss_n), 32'd0);
                check("ready_busy", 32'({o.ready, o.busy}), 32'b01);
                check("rv_quiet", 32'(o.rv), 32'd0);
                if (k == 1) check("mosi_start", 32'(o.mosi), 32'(cmd[9]));
                else if (k <= 11) check("mosi_bit", 32'(o.mosi), 32'(cmd[11 - k]));
                else if (k <= 11 + ta) check("mosi_wait", 32'(o.mosi), 32'd0);
            end else if (k == n + 1) begin
                if (rd) begin
                    if (z) model_rsp_z = rbyte; else model_rsp_a = rbyte;
                end
                exp_rsp = z ? model_rsp_z : model_rsp_a;
                check("end_ss_high", 32'(o.ss_n), 32'd1);
                check("end_ready_busy", 32'({o.ready, o.busy}), 32'b01);
                check("end_rv", 32'(o.rv), 32'(rd));
                check("end_rdata", 32'(o.rdata), 32'(exp_rsp));
                end_data = o.rdata;
            end else begin
                check("idle_ready_busy", 32'({o.ready, o.busy}), 32'b10);
                check("idle_ss", 32'(o.ss_n), 32'd1);
                check("idle_rv", 32'(o.rv), 32'd0);
            end
            rv_count += int'(o.rv);
        end
    endtask

    vec_t vecs[8];
    int   rvc;
    logic [7:0] ed;

    initial begin
        vecs[0] = '{0, 10'h03C, 8'h00, 0, 0, 8'h00};
        vecs[1] = '{0, 10'h300, 8'hA5, 0, 1, 8'hA5};
        vecs[2] = '{0, 10'h155, 8'h00, 0, 0, 8'hA5};
        vecs[3] = '{0, 10'h2F0, 8'hFF, 0, 0, 8'hA5};
        vecs[4] = '{0, 10'h3FF, 8'h3C, 1, 1, 8'h3C};
        vecs[5] = '{1, 10'h300, 8'h5A, 0, 1, 8'h5A};
        vecs[6] = '{1, 10'h0AA, 8'h00, 0, 0, 8'h5A};
        vecs[7] = '{1, 10'h3C3, 8'h81, 1, 1, 8'h81};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ss", 32'(obs_a.ss_n), 32'd1);
        check("rst_mosi", 32'(obs_a.mosi), 32'd0);
        check("rst_rv", 32'(obs_a.rv), 32'd0);
        check("rst_rdata", 32'(obs_a.rdata), 32'd0);
        check("rst_ready_busy", 32'({obs_a.ready, obs_a.busy}), 32'b10);
        check("rst_z_ss_ready", 32'({obs_z.ss_n, obs_z.ready}), 32'b11);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Table vectors
        foreach (vecs[i]) begin
            do_frame(vecs[i].z, vecs[i].cmd, vecs[i].rbyte, vecs[i].noisy, 0, rvc, ed);
            check("vec_rv_count", 32'(rvc), 32'(vecs[i].exp_rv));
            check("vec_rdata", 32'(ed), 32'(vecs[i].exp_data));
        end

        // Back-to-back with cmd_valid held through busy periods
        do_frame(0, 10'h012, 8'h00, 1, 0, rvc, ed);
        do_frame(0, 10'h16D, 8'h00, 1, 0, rvc, ed);
        do_frame(0, 10'h2C4, 8'h00, 1, 0, rvc, ed);
        do_frame(0, 10'h3E7, 8'h69, 1, 0, rvc, ed);
        check("b2b_read", 32'(ed), 32'h69);

        // Random frames against the reference
        for (int i = 0; i < 30; i++) begin
            logic [9:0] c;
            c = 10'($urandom);
            if ($urandom_range(0, 1) == 1) c[9:8] = 2'b11;
            do_frame(($urandom_range(0, 3) == 0), c, 8'($urandom), bit'($urandom_range(0, 1)), 0, rvc, ed);
        end

        // Reset in the middle of a read capture
        do_frame(0, 10'h3A0, 8'hC3, 0, 16, rvc, ed);
        #2;
        check("mid_ss_low", 32'(obs_a.ss_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_ss_high", 32'(obs_a.ss_n), 32'd1);
        check("async_rv", 32'(obs_a.rv), 32'd0);
        check("async_rdata", 32'(obs_a.rdata), 32'd0);
        check("async_ready", 32'({obs_a.ready, obs_a.busy}), 32'b10);
        model_rsp_a = 8'h00;
        model_rsp_z = 8'h00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'({obs_a.rv, obs_a.ss_n}), 32'b01);
        end
        do_frame(0, 10'h3F0, 8'h96, 0, 0, rvc, ed);
        check("post_rst_read", 32'({rvc[7:0], ed}), 32'h0196);
        do_frame(1, 10'h300, 8'h5A, 0, 0, rvc, ed);
        check("post_rst_z_read", 32'({rvc[7:0], ed}), 32'h015A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
